writeback_arbiter: RTL and testbench

- Sits directly downstream of the execution units (ALU, branch, mul/div, load-store) and consumes their writeback outputs: done, id, rd.
- Each cycle, selects at most one completed result by round-robin and acknowledges the producing unit.
- Registers the selected result into a single output stage that feeds the register-file write port and the ID-tracking logic.
- Provides a stall-tolerant valid/ready handshake so that a held register-file port back-pressures the units.

---
 rtl/writeback_arbiter_pkg.sv | 22 ++
 rtl/writeback_arbiter_rr_select.sv | 35 +++
 rtl/writeback_arbiter.sv | 116 +++++++++++
 tb/tb_writeback_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared configuration and payload types for the writeback path.
package writeback_arbiter_pkg;

  localparam int unsigned NUM_WB_UNITS  = 4;
  localparam int unsigned WB_ID_WIDTH   = 3;
  localparam int unsigned WB_DATA_WIDTH = 32;

  // Width of a unit index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned WB_UNIT_WIDTH = idx_width(NUM_WB_UNITS);

  // One writeback result as seen by the register file and ID tracker.
  typedef struct packed {
    logic [WB_ID_WIDTH-1:0]   id;
    logic [WB_DATA_WIDTH-1:0] data;
    logic [WB_UNIT_WIDTH-1:0] unit;
  } wb_packet_t;

endpackage

// File: rtl/writeback_arbiter_rr_select.sv
// Round-robin priority select: first set request at or above ptr, with wrap.
// Purely combinational so the issue logic can reuse it.
module rr_priority_select #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_c,
  output logic [IDX_W-1:0] grant_idx_c,
  output logic             any_c
);

  // Two passes: requests at/above the pointer win, then the wrapped lower ones.
  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    any_c       = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!any_c && req[i] && (IDX_W'(i) >= ptr)) begin
        any_c       = 1'b1;
        grant_c[i]  = 1'b1;
        grant_idx_c = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(N); i++) begin
      if (!any_c && req[i]) begin
        any_c       = 1'b1;
        grant_c[i]  = 1'b1;
        grant_idx_c = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: round-robin selection of completed execution-unit
// results into a single registered output stage with valid/ready stalls.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned NUM_UNITS  = NUM_WB_UNITS,
  parameter int unsigned ID_WIDTH   = WB_ID_WIDTH,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_UNITS-1:0]             unit_done,
  input  logic [NUM_UNITS*ID_WIDTH-1:0]    unit_id,
  input  logic [NUM_UNITS*DATA_WIDTH-1:0]  unit_rd,
  output logic [NUM_UNITS-1:0]             unit_ack,
  output logic                             wb_valid,
  output logic [ID_WIDTH-1:0]              wb_id,
  output logic [DATA_WIDTH-1:0]            wb_data,
  output logic [idx_width(NUM_UNITS)-1:0]  wb_unit,
  input  logic                             wb_ready
);

  localparam int unsigned IDX_W = idx_width(NUM_UNITS);

  logic                   free_c;
  logic [NUM_UNITS-1:0]   req_c;
  logic [NUM_UNITS-1:0]   grant_c;
  logic [IDX_W-1:0]       grant_idx_c;
  logic                   any_c;

  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       rr_ptr_d;
  logic                   wb_valid_d;
  logic [ID_WIDTH-1:0]    wb_id_d;
  logic [DATA_WIDTH-1:0]  wb_data_d;
  logic [IDX_W-1:0]       wb_unit_d;

  logic [ID_WIDTH-1:0]    id_arr   [NUM_UNITS];
  logic [DATA_WIDTH-1:0]  data_arr [NUM_UNITS];

  // Unpack the flat per-unit buses.
  for (genvar g = 0; g < int'(NUM_UNITS); g++) begin : g_unpack
    assign id_arr[g]   = unit_id[g*ID_WIDTH +: ID_WIDTH];
    assign data_arr[g] = unit_rd[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Stage can take a new result when empty or being drained this cycle;
  // no unit is acknowledged while reset is held.
  assign free_c = ~wb_valid | wb_ready;
  assign req_c  = unit_done & {NUM_UNITS{free_c & rst}};

  rr_priority_select #(
    .N     (NUM_UNITS),
    .IDX_W (IDX_W)
  ) u_select (
    .req         (req_c),
    .ptr         (rr_ptr),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .any_c       (any_c)
  );

  assign unit_ack = grant_c;

  // Next-state for the output stage and round-robin pointer.
  always_comb begin
    rr_ptr_d   = rr_ptr;
    wb_valid_d = wb_valid;
    wb_id_d    = wb_id;
    wb_data_d  = wb_data;
    wb_unit_d  = wb_unit;
    if (free_c) begin
      wb_valid_d = any_c;
      if (any_c) begin
        wb_id_d   = id_arr[grant_idx_c];
        wb_data_d = data_arr[grant_idx_c];
        wb_unit_d = grant_idx_c;
        rr_ptr_d  = (grant_idx_c == IDX_W'(NUM_UNITS - 1)) ? '0 : grant_idx_c + IDX_W'(1);
      end
    end
  end

  // Output stage and pointer registers; reset drops any in-flight result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      wb_valid <= 1'b0;
      wb_id    <= '0;
      wb_data  <= '0;
      wb_unit  <= '0;
    end else begin
      rr_ptr   <= rr_ptr_d;
      wb_valid <= wb_valid_d;
      wb_id    <= wb_id_d;
      wb_data  <= wb_data_d;
      wb_unit  <= wb_unit_d;
    end
  end

`ifndef SYNTHESIS
  // At most one unit accepted per cycle.
  ack_onehot_a: assert property (@(posedge clk) disable iff (!rst)
    $onehot0(unit_ack));

  // A stalled result must not change under the consumer.
  hold_stable_a: assert property (@(posedge clk) disable iff (!rst)
    (wb_valid && !wb_ready) |=> ($stable(wb_id) && $stable(wb_data)));

  // Units keep done asserted until acknowledged.
  for (genvar g = 0; g < int'(NUM_UNITS); g++) begin : g_done_hold
    done_hold_a: assert property (@(posedge clk) disable iff (!rst)
      (unit_done[g] && !unit_ack[g]) |=> unit_done[g]);
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios then random
// traffic, all checked against a transaction-level reference model.
module tb_writeback_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned XW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      unit_done;
  logic [N*IW-1:0]   unit_id;
  logic [N*DW-1:0]   unit_rd;
  logic [N-1:0]      unit_ack;
  logic              wb_valid;
  logic [IW-1:0]     wb_id;
  logic [DW-1:0]     wb_data;
  logic [XW-1:0]     wb_unit;
  logic              wb_ready;

  writeback_arbiter #(.NUM_UNITS(N), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .unit_done (unit_done),
    .unit_id   (unit_id),
    .unit_rd   (unit_rd),
    .unit_ack  (unit_ack),
    .wb_valid  (wb_valid),
    .wb_id     (wb_id),
    .wb_data   (wb_data),
    .wb_unit   (wb_unit),
    .wb_ready  (wb_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Unit-side pending results.
  bit            u_done [N];
  logic [IW-1:0] u_id   [N];
  logic [DW-1:0] u_rd   [N];

  // Reference model of the output stage.
  bit            m_valid;
  logic [IW-1:0] m_id;
  logic [DW-1:0] m_data;
  int            m_unit;
  int            m_ptr;

  logic [N-1:0]  last_ack;
  logic [N-1:0]  rot_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h expected=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      unit_done[i]         = u_done[i];
      unit_id[i*IW +: IW]  = u_id[i];
      unit_rd[i*DW +: DW]  = u_rd[i];
    end
  endtask

  task automatic present(input int u, input logic [IW-1:0] id, input logic [DW-1:0] rd);
    u_done[u] = 1'b1;
    u_id[u]   = id;
    u_rd[u]   = rd;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_id    = '0;
    m_data  = '0;
    m_unit  = 0;
    m_ptr   = 0;
  endtask

  // Round-robin choice from the spec rules: nearest pending unit at or after
  // the pointer, going around the ring; none while the stage is blocked.
  function automatic int model_pick();
    if (m_valid && !wb_ready) return -1;
    for (int k = 0; k < int'(N); k++) begin
      int j = (m_ptr + k) % int'(N);
      if (u_done[j]) return j;
    end
    return -1;
  endfunction

  // One clock: check combinational ack, advance model, check registered output.
  task automatic step();
    int  g;
    bit  free;
    logic [N-1:0] exp_ack;
    drive();
    #1;
    g       = model_pick();
    exp_ack = (g >= 0) ? N'(1 << g) : '0;
    last_ack = unit_ack;
    check("ack", 64'(unit_ack), 64'(exp_ack));
    free = !m_valid || wb_ready;
    @(posedge clk);
    if (free) begin
      if (g >= 0) begin
        m_valid   = 1'b1;
        m_id      = u_id[g];
        m_data    = u_rd[g];
        m_unit    = g;
        m_ptr     = (g + 1) % int'(N);
        u_done[g] = 1'b0;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("wb_valid", 64'(wb_valid), 64'(m_valid));
    if (m_valid) begin
      check("wb_id",   64'(wb_id),   64'(m_id));
      check("wb_data", 64'(wb_data), 64'(m_data));
      check("wb_unit", 64'(wb_unit), 64'(m_unit));
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) begin
      u_done[i] = 1'b1;
      u_id[i]   = '0;
      u_rd[i]   = '0;
    end
    model_reset();
    wb_ready = 1'b1;
    rst      = 1'b0;
    drive();

    // Reset state, with every unit requesting: no ack may leak out.
    #12;
    check("rst_ack",   64'(unit_ack), 64'(0));
    check("rst_valid", 64'(wb_valid), 64'(0));
    check("rst_id",    64'(wb_id),    64'(0));
    check("rst_data",  64'(wb_data),  64'(0));
    check("rst_unit",  64'(wb_unit),  64'(0));
    for (int i = 0; i < int'(N); i++) u_done[i] = 1'b0;
    drive();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // All units continuously done: grants rotate 0,1,2,3,0.
    for (int i = 0; i < int'(N); i++) present(i, IW'(i + 1), 32'hA000_0000 + DW'(i));
    for (int r = 0; r < 5; r++) begin
      int gu;
      step();
      check("rot_ack", 64'(last_ack), 64'(rot_exp[r]));
      gu = (r % int'(N));
      if (r < 4) present(gu, IW'(r + 4), 32'hB000_0000 + DW'(r));
    end
    for (int r = 0; r < 4; r++) step();

    // Single result from unit 2 with pointer at 0.
    present(2, 3'd5, 32'hDEAD_BEEF);
    step();
    check("single_ack",   64'(last_ack), 64'(4'b0100));
    check("single_valid", 64'(wb_valid), 64'(1));
    check("single_id",    64'(wb_id),    64'(5));
    check("single_data",  64'(wb_data),  64'(32'hDEAD_BEEF));
    check("single_unit",  64'(wb_unit),  64'(2));

    // Wrap-around from pointer 3 with units 0 and 3 pending.
    present(0, 3'd1, 32'h0000_0100);
    present(3, 3'd2, 32'h0000_0300);
    step();
    check("wrap_first",  64'(last_ack), 64'(4'b1000));
    step();
    check("wrap_second", 64'(last_ack), 64'(4'b0001));
    step();

    // Stall for three cycles, then release with no bubble.
    present(2, 3'd6, 32'h1234_5678);
    step();
    wb_ready = 1'b0;
    present(0, 3'd3, 32'h0000_AAAA);
    present(1, 3'd4, 32'h0000_BBBB);
    for (int s = 0; s < 3; s++) begin
      step();
      check("stall_ack",  64'(last_ack), 64'(0));
      check("stall_data", 64'(wb_data),  64'(32'h1234_5678));
    end
    wb_ready = 1'b1;
    step();
    check("unstall_ack",  64'(last_ack), 64'(4'b0001));
    check("unstall_data", 64'(wb_data),  64'(32'h0000_AAAA));
    step();
    check("unstall_next", 64'(wb_unit),  64'(1));

    // Idle cycles.
    for (int s = 0; s < 5; s++) step();
    check("idle_valid", 64'(wb_valid), 64'(0));

    // Asynchronous reset mid-cycle while a result is held.
    wb_ready = 1'b0;
    present(3, 3'd7, 32'hCAFE_F00D);
    step();
    #2;
    rst = 1'b0;
    for (int i = 0; i < int'(N); i++) u_done[i] = 1'b0;
    drive();
    #1;
    check("arst_valid", 64'(wb_valid), 64'(0));
    check("arst_data",  64'(wb_data),  64'(0));
    check("arst_ack",   64'(unit_ack), 64'(0));
    model_reset();
    @(negedge clk);
    rst      = 1'b1;
    wb_ready = 1'b1;
    present(1, 3'd2, 32'h5555_0001);
    step();
    check("post_rst_unit", 64'(wb_unit), 64'(1));
    present(0, 3'd1, 32'h5555_0000);
    present(3, 3'd3, 32'h5555_0003);
    step();
    check("post_rst_ptr", 64'(last_ack), 64'(4'b1000));

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      wb_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < int'(N); i++)
        if (!u_done[i] && $urandom_range(0, 1) == 1)
          present(i, IW'($urandom), DW'($urandom));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
